// File: rtl/huffman_pkg.sv
// huffman_pkg: shared parameters and types for the huffman front-end stages
package huffman_pkg;
  localparam int FT_DATA_WIDTH  = 8;
  localparam int FT_COUNT_WIDTH = 32;
  localparam int FT_TABLE_SIZE  = 1 << FT_DATA_WIDTH;
  localparam int FTS_DATA_WIDTH  = FT_DATA_WIDTH;
  localparam int FTS_COUNT_WIDTH = FT_COUNT_WIDTH;
  localparam int FTS_TABLE_SIZE  = FT_TABLE_SIZE;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} fts_state_e;
endpackage

// File: rtl/freq_table_scanner.sv
// freq_table_scanner: walks a histogram in symbol order, emitting nonzero entries and totals
module freq_table_scanner
  import huffman_pkg::*;
#(
  parameter int TABLE_SIZE  = FTS_TABLE_SIZE,
  parameter int DATA_WIDTH  = FTS_DATA_WIDTH,
  parameter int COUNT_WIDTH = FTS_COUNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic [COUNT_WIDTH-1:0]            freq_table [TABLE_SIZE],
  input  logic                              start_in,
  input  logic                              ready_in,
  output logic [DATA_WIDTH-1:0]             symbol_out,
  output logic [COUNT_WIDTH-1:0]            count_out,
  output logic                              valid_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [DATA_WIDTH:0]               distinct_out,
  output logic [COUNT_WIDTH+DATA_WIDTH-1:0] total_out
);
  localparam int TW = COUNT_WIDTH + DATA_WIDTH;
  fts_state_e state, state_n;
  logic [DATA_WIDTH-1:0] index;
  logic [COUNT_WIDTH-1:0] entry;
  logic hit, last;
  assign entry = freq_table[index];
  assign hit = entry != '0;
  assign last = index == DATA_WIDTH'(TABLE_SIZE - 1);
  assign valid_out = state == EMIT;
  assign busy_out = state != IDLE;
  assign done_out = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_in ? SCAN : IDLE;
      SCAN:    state_n = hit ? EMIT : (last ? DONE : SCAN);
      EMIT:    state_n = !ready_in ? EMIT : (last ? DONE : SCAN);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state        <= IDLE;
      index        <= '0;
      symbol_out   <= '0;
      count_out    <= '0;
      distinct_out <= '0;
      total_out    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_in) begin
        index        <= '0;
        distinct_out <= '0;
        total_out    <= '0;
      end
      if (state == SCAN && hit) begin
        symbol_out   <= index;
        count_out    <= entry;
        total_out    <= total_out + TW'(entry);
        distinct_out <= distinct_out + (DATA_WIDTH+1)'(1);
      end
      // index stops at the last entry so a scan can never wrap back to symbol 0
      if (((state == SCAN && !hit) || (state == EMIT && ready_in)) && !last)
        index <= index + DATA_WIDTH'(1);
    end
  end
endmodule
